// File: rtl/fpga_key_write_sequencer.sv
// Board input stage for the register-file wrapper: debounced keys load a 32-bit
// write word from the switches and commit it as a single write-enable pulse.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_raw_n,
    output logic stable_n,
    output logic press
);
    logic             s1, s2, stable_d;
    logic [CNT_W-1:0] cnt;

    // A new level is accepted once it has survived DEBOUNCE_CYCLES+1 consecutive
    // synchronized samples; any sample matching the old level restarts the count.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            stable_n <= 1'b1;
            stable_d <= 1'b1;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= key_raw_n;
            s2       <= s1;
            stable_d <= stable_n;
            press    <= stable_d & ~stable_n;
            if (s2 == stable_n) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                stable_n <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module fpga_key_write_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  key_n,
    input  logic [17:0] sw,
    output logic [4:0]  wsel,
    output logic [4:0]  rsel1,
    output logic [4:0]  rsel2,
    output logic [31:0] wdat,
    output logic        WEN,
    output logic        busy,
    output logic [7:0]  wr_count
);
    localparam int NUM_KEYS = 4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    logic [1:0]          state;
    logic [17:0]         sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] stable_n, press;
    logic [6:0]          unused_bits;

    // Key 2 is the board reset and never reaches this logic.
    genvar i;
    for (i = 0; i < NUM_KEYS; i++) begin : g_key
        if (i != 2) begin : g_db
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .CLK      (CLK),
                .nRST     (nRST),
                .key_raw_n(key_n[i]),
                .stable_n (stable_n[i]),
                .press    (press[i])
            );
        end else begin : g_tie
            assign stable_n[i] = 1'b1;
            assign press[i]    = 1'b0;
        end
    end

    assign unused_bits = {key_n[2], stable_n[2:0], press[2], sw_s2[17:16]};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    assign rsel1 = sw_s2[9:5];
    assign rsel2 = sw_s2[14:10];

    // wsel/wdat are only written in IDLE, so they hold steady through the commit.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            wsel     <= '0;
            wdat     <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[3]) begin
                        wsel  <= sw_s2[4:0];
                        state <= WRITE;
                    end else begin
                        if (press[0]) wdat[15:0]  <= sw_s2[15:0];
                        if (press[1]) wdat[31:16] <= sw_s2[15:0];
                    end
                end
                WRITE: begin
                    wr_count <= wr_count + 8'd1;
                    state    <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (stable_n[3]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign WEN  = (state == WRITE);
    assign busy = (state != IDLE);
endmodule
